alu_pipelined: RTL and testbench
================================

// Module: alu_pipelined
// PURPOSE
//  Handshaked, registered, width-parametrised ALU; next-generation execute-stage ALU of the ARM core.
//  Adds true two's-complement NZCV with carry, ADC/SBC/RSC, and a multi-cycle MUL opcode.
//  Sits between register-read/shifter and writeback.
//  Single-cycle ops return one cycle after accept; MUL iterates shift-add over WIDTH cycles.
// PARAMETERS
//  WIDTH      32  operand/result width in bits (>=8)
//  MUL_EN     1   1 = opcode 5'b10000 (MUL) implemented; 0 = MUL treated as undefined
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  in_valid    in   1      operation presented
//  in_ready    out  1      operation accepted when in_valid & in_ready at clk edge
//  operation   in   5      opcode (ARM data-processing encoding, 5'b10000 = MUL)
//  data1       in   WIDTH  Rn operand
//  data2       in   WIDTH  shifter operand
//  flags_in    in   4      current CPSR flags {V,N,C,Z}; C is the carry-in; C/V preserved by logic ops
//  out_valid   out  1      result/flags valid
//  out_ready   in   1      consumer takes result when out_valid & out_ready
//  result      out  WIDTH  registered result
//  flags       out  4      registered flags: [0]=Z [1]=C [2]=N [3]=V
//  writeback   out  1      1 = result must be written to Rd (0 for TST/TEQ/CMP/CMN/undefined)
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, result=0, flags=0, writeback=0; in_ready=1 after release.
//  FSM: IDLE -> (accept non-MUL) DONE; IDLE -> (accept MUL) MUL; MUL -> DONE when step count hits WIDTH;
//   DONE -> IDLE on out handshake w/o new accept; DONE -> DONE/MUL on out handshake with same-cycle accept.
//  in_ready = (state==IDLE) | (state==DONE & out_ready); always 0 in MUL.
//  out_valid = (state==DONE); result/flags/writeback stable while out_valid & !out_ready.
//  Latency: non-MUL out_valid rises 1 cycle after accept; MUL rises exactly WIDTH+1 cycles after accept.
//  Ops: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN (00000..01111), MUL (10000).
//  Arithmetic: one WIDTH+1-bit adder: a + ~b + 1 (SUB/CMP), b + ~a + 1 (RSB), a + b (ADD/CMN),
//   a + b + C (ADC), a + ~b + C (SBC), b + ~a + C (RSC); C out = bit WIDTH (SUB: C=1 means no borrow).
//  V (arith): operand-sign mismatch rule on the adder inputs: V = (x[MSB]==y[MSB]) & (s[MSB]!=x[MSB]).
//  N = result[MSB]; Z = (result==0) for every defined op, including compare/test (result computed, not written).
//  Logic ops and MOV/MVN: C, V copied from flags_in. MUL: low WIDTH bits of product; C, V copied from flags_in.
//  Undefined opcode (incl. MUL when MUL_EN=0): accepted, result=0, writeback=0, flags=flags_in, 1-cycle latency.
//  operation/data/flags_in are sampled only at accept; later changes have no effect on an op in flight.
//  Reset asserted mid-MUL or in DONE: op discarded, outputs to reset values immediately (async).
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_AND..OP_MVN, OP_MUL), flag bit indices
//   (FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3), FSM state encoding (ST_IDLE, ST_MUL, ST_DONE).
//  One sub-module alu_datapath: purely combinational WIDTH-param result/flags/writeback for opcodes 0..15.
//  Top holds FSM, output registers, MUL multiplicand/multiplier/accumulator shift registers and step counter.
// TESTING (WIDTH=32)
//  ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, flags 4'b1100 (V,N), writeback 1, out_valid next cycle.
//  SUB 3-7 -> 0xFFFFFFFC, flags 4'b0100; CMP 7,7 -> flags 4'b0011 (Z,C), writeback 0.
//  ADC 0xFFFFFFFF + 0x0 with flags_in C=1 -> result 0, flags 4'b0011; SBC 5-3 with C=0 -> 1, flags 4'b0010.
//  MUL 6*7 -> 42, out_valid exactly 33 cycles after accept, in_ready 0 throughout; 0x10000*0x10000 -> 0, Z=1.
//  Backpressure: out_ready=0 for 3 cycles -> outputs held, in_ready 0; then out_ready=1 with in_valid=1 ->
//   new op accepted on same edge, its result valid next cycle (back-to-back ADDs at full throughput).
//  Reset low during MUL step 10 -> out_valid 0 at once; after release in_ready 1; undefined 5'b10101 -> result 0, flags=flags_in.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the execute-stage ALU.
//   - Opcodes in ARM data-processing order (5-bit, MUL lives above the 16 DP ops).
//   - Flag bit positions within the 4-bit {V,N,C,Z} flag vector.
//   - FSM state encoding for the top-level handshake/MUL controller.
package alu_pkg;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_EOR = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_RSB = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SBC = 5'b00110;
  localparam logic [4:0] OP_RSC = 5'b00111;
  localparam logic [4:0] OP_TST = 5'b01000;
  localparam logic [4:0] OP_TEQ = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_CMN = 5'b01011;
  localparam logic [4:0] OP_ORR = 5'b01100;
  localparam logic [4:0] OP_MOV = 5'b01101;
  localparam logic [4:0] OP_BIC = 5'b01110;
  localparam logic [4:0] OP_MVN = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: combinational result/flags/writeback for the 16 data-processing
// opcodes (0..15). A single WIDTH+1-bit adder serves every arithmetic op; the
// operand swap/invert and carry-in select which of the eight forms it computes.
// Ports:
//   op        in   4      low opcode bits (0..15)
//   a         in   WIDTH  Rn operand
//   b         in   WIDTH  shifter operand
//   c_in      in   1      current C flag (carry-in, preserved by logic ops)
//   v_in      in   1      current V flag (preserved by logic ops)
//   result    out  WIDTH  computed result (also produced for compare/test)
//   flags     out  4      [0]=Z [1]=C [2]=N [3]=V
//   writeback out  1      0 for TST/TEQ/CMP/CMN
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             writeback
);

  logic [4:0]       op5;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             is_arith;
  logic [WIDTH:0]   sum;
  logic             add_v;

  assign op5 = {1'b0, op};

  // Adder operand selection: x is the operand whose sign the V rule tracks.
  always_comb begin
    add_x    = a;
    add_y    = b;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (op5)
      OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1; end
      OP_RSB:         begin add_x = b; add_y = ~a; add_cin = 1'b1; end
      OP_ADD, OP_CMN: begin add_cin = 1'b0; end
      OP_ADC:         begin add_cin = c_in; end
      OP_SBC:         begin add_y = ~b; add_cin = c_in; end
      OP_RSC:         begin add_x = b; add_y = ~a; add_cin = c_in; end
      default:        is_arith = 1'b0;
    endcase
  end

  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) & (sum[WIDTH-1] != add_x[WIDTH-1]);

  always_comb begin
    result = sum[WIDTH-1:0];
    case (op5)
      OP_AND, OP_TST: result = a & b;
      OP_EOR, OP_TEQ: result = a ^ b;
      OP_ORR:         result = a | b;
      OP_MOV:         result = b;
      OP_BIC:         result = a & ~b;
      OP_MVN:         result = ~b;
      default:        result = sum[WIDTH-1:0];
    endcase
  end

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = is_arith ? sum[WIDTH] : c_in;
    flags[FLAG_V] = is_arith ? add_v : v_in;
  end

  // Compare/test ops (8..11) only update flags.
  assign writeback = !(op5 == OP_TST || op5 == OP_TEQ || op5 == OP_CMP || op5 == OP_CMN);

endmodule

// File: rtl/alu_pipelined.sv
// alu_pipelined: handshaked, registered execute-stage ALU with NZCV flags and
// an optional iterative shift-add MUL (one multiplier bit per cycle).
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   in_valid   in   1      operation presented
//   in_ready   out  1      operation accepted when in_valid & in_ready at clk edge
//   operation  in   5      opcode (0..15 data-processing, 16 = MUL)
//   data1      in   WIDTH  Rn operand
//   data2      in   WIDTH  shifter operand
//   flags_in   in   4      current flags {V,N,C,Z}
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer takes result when out_valid & out_ready
//   result     out  WIDTH  registered result
//   flags      out  4      registered flags [0]=Z [1]=C [2]=N [3]=V
//   writeback  out  1      result must be written to Rd
module alu_pipelined
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       operation,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             writeback
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg;
  logic             writeback_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    step_reg;
  logic             c_saved_reg;
  logic             v_saved_reg;

  logic             accept;
  logic             is_mul;
  logic             is_undef;
  logic [WIDTH-1:0] dp_result;
  logic [3:0]       dp_flags;
  logic             dp_writeback;
  logic [3:0]       mul_flags;

  assign in_ready = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mul   = (MUL_EN == 1'b1) && (operation == OP_MUL);
  // Anything with bit 4 set other than an enabled MUL is undefined.
  assign is_undef = operation[4] & ~is_mul;

  alu_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .op        (operation[3:0]),
    .a         (data1),
    .b         (data2),
    .c_in      (flags_in[FLAG_C]),
    .v_in      (flags_in[FLAG_V]),
    .result    (dp_result),
    .flags     (dp_flags),
    .writeback (dp_writeback)
  );

  // MUL keeps the C/V captured at accept; Z/N come from the final product.
  always_comb begin
    mul_flags         = 4'b0000;
    mul_flags[FLAG_Z] = (acc_reg == '0);
    mul_flags[FLAG_N] = acc_reg[WIDTH-1];
    mul_flags[FLAG_C] = c_saved_reg;
    mul_flags[FLAG_V] = v_saved_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      flags_reg     <= 4'b0000;
      writeback_reg <= 1'b0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      step_reg      <= '0;
      c_saved_reg   <= 1'b0;
      v_saved_reg   <= 1'b0;
    end else if (accept) begin
      // Accept is possible from IDLE, or from DONE in the same edge the
      // consumer takes the previous result.
      if (is_mul) begin
        state_reg   <= ST_MUL;
        mcand_reg   <= data1;
        mplier_reg  <= data2;
        acc_reg     <= '0;
        step_reg    <= '0;
        c_saved_reg <= flags_in[FLAG_C];
        v_saved_reg <= flags_in[FLAG_V];
      end else if (is_undef) begin
        state_reg     <= ST_DONE;
        result_reg    <= '0;
        flags_reg     <= flags_in;
        writeback_reg <= 1'b0;
      end else begin
        state_reg     <= ST_DONE;
        result_reg    <= dp_result;
        flags_reg     <= dp_flags;
        writeback_reg <= dp_writeback;
      end
    end else if (state_reg == ST_MUL) begin
      // WIDTH shift-add steps, then one edge to publish the product.
      if (step_reg == STEP_LAST) begin
        state_reg     <= ST_DONE;
        result_reg    <= acc_reg;
        flags_reg     <= mul_flags;
        writeback_reg <= 1'b1;
      end else begin
        acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        step_reg   <= step_reg + 1'b1;
      end
    end else if (state_reg == ST_DONE) begin
      if (out_ready) begin
        state_reg <= ST_IDLE;
      end
    end else if (state_reg != ST_IDLE) begin
      // Unused encoding: recover to IDLE.
      state_reg <= ST_IDLE;
    end
  end

  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;
  assign writeback = writeback_reg;

endmodule

// File: tb/tb_alu_pipelined.sv
// Testbench for alu_pipelined (WIDTH=32): table-driven vectors plus a random
// model-checked phase, all compared by a scoreboard at the output handshake,
// followed by hand-written backpressure, MUL latency and async-reset sequences.
module tb_alu_pipelined;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    operation;
  logic [W-1:0]  data1;
  logic [W-1:0]  data2;
  logic [3:0]    flags_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic          writeback;

  alu_pipelined #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .data1     (data1),
    .data2     (data2),
    .flags_in  (flags_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .writeback (writeback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         wb;
  } exp_t;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   fin;
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         wb;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [3:0] fin, input logic [W-1:0] res, input logic [3:0] flg,
                              input logic wb);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.fin = fin; v.res = res; v.flg = flg; v.wb = wb;
    return v;
  endfunction

  // Reference model: carry from a 33-bit sum, overflow from exact signed arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] fin);
    exp_t         e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         arith;
    logic [W:0]   s;
    longint       sv;
    e.op = op; e.res = '0; e.flg = fin; e.wb = 1'b1;
    x = a; y = b; cin = 1'b0; arith = 1'b0;
    case (op)
      5'd0, 5'd8:  e.res = a & b;
      5'd1, 5'd9:  e.res = a ^ b;
      5'd12:       e.res = a | b;
      5'd13:       e.res = b;
      5'd14:       e.res = a & ~b;
      5'd15:       e.res = ~b;
      5'd2, 5'd10: begin arith = 1'b1; y = ~b; cin = 1'b1; end
      5'd3:        begin arith = 1'b1; x = b; y = ~a; cin = 1'b1; end
      5'd4, 5'd11: arith = 1'b1;
      5'd5:        begin arith = 1'b1; cin = fin[1]; end
      5'd6:        begin arith = 1'b1; y = ~b; cin = fin[1]; end
      5'd7:        begin arith = 1'b1; x = b; y = ~a; cin = fin[1]; end
      5'd16:       e.res = a * b;
      default: begin
        e.wb = 1'b0;
        return e;
      end
    endcase
    if (arith) begin
      s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
      e.res = s[W-1:0];
      sv = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
      e.flg[1] = s[W];
      e.flg[3] = (sv != longint'($signed(e.res)));
    end
    e.flg[2] = e.res[W-1];
    e.flg[0] = (e.res == '0);
    if (op >= 5'd8 && op <= 5'd11) e.wb = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Present one op and wait (bounded) for it to be accepted; returns #1 after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] fin, input logic push, input exp_t e);
    int guard;
    operation = op; data1 = a; data2 = b; flags_in = fin; in_valid = 1'b1;
    if (push) sb_q.push_back(e);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept op=%b", op);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Scoreboard: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=%h/%b/%b required=none", result, flags, writeback);
      end else begin
        mon_e = sb_q.pop_front();
        if (result !== mon_e.res || flags !== mon_e.flg || writeback !== mon_e.wb) begin
          failures++;
          $display("FAIL txn op=%b actual=%h/%b/%b required=%h/%b/%b", mon_e.op,
                   result, flags, writeback, mon_e.res, mon_e.flg, mon_e.wb);
        end else begin
          $display("ok   txn op=%b result=%h flags=%b wb=%b", mon_e.op, result, flags, writeback);
        end
      end
    end
  end

  initial begin
    exp_t         e;
    logic [4:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rf;
    int           k;
    logic         ready_low;

    reset = 1'b0; in_valid = 1'b0; operation = 5'd0; data1 = '0; data2 = '0;
    flags_in = 4'b0000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_result", result, W'(0));
    check("reset_flags", W'(flags), W'(0));
    check("reset_writeback", W'(writeback), W'(0));
    reset = 1'b1;
    #1;
    check("post_reset_in_ready", W'(in_ready), W'(1));

    // Directed vectors: op, a, b, flags_in, result, flags{V,N,C,Z}, writeback
    vecs.push_back(mk(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 4'b1100, 1'b1));
    vecs.push_back(mk(OP_SUB, 32'd3,        32'd7,        4'b0000, 32'hFFFFFFFC, 4'b0100, 1'b1));
    vecs.push_back(mk(OP_CMP, 32'd7,        32'd7,        4'b0000, 32'h00000000, 4'b0011, 1'b0));
    vecs.push_back(mk(OP_ADC, 32'hFFFFFFFF, 32'h0,        4'b0010, 32'h00000000, 4'b0011, 1'b1));
    vecs.push_back(mk(OP_SBC, 32'd5,        32'd3,        4'b0000, 32'h00000001, 4'b0010, 1'b1));
    vecs.push_back(mk(OP_RSB, 32'd3,        32'd10,       4'b0000, 32'h00000007, 4'b0010, 1'b1));
    vecs.push_back(mk(OP_RSC, 32'd3,        32'd5,        4'b0000, 32'h00000001, 4'b0010, 1'b1));
    vecs.push_back(mk(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 4'b1010, 32'hF000F000, 4'b1110, 1'b1));
    vecs.push_back(mk(OP_EOR, 32'h000000FF, 32'h0000000F, 4'b0000, 32'h000000F0, 4'b0000, 1'b1));
    vecs.push_back(mk(OP_TST, 32'h0000000F, 32'h000000F0, 4'b0000, 32'h00000000, 4'b0001, 1'b0));
    vecs.push_back(mk(OP_TEQ, 32'd5,        32'd5,        4'b1000, 32'h00000000, 4'b1001, 1'b0));
    vecs.push_back(mk(OP_CMN, 32'hFFFFFFFF, 32'd1,        4'b0000, 32'h00000000, 4'b0011, 1'b0));
    vecs.push_back(mk(OP_ORR, 32'h0000000F, 32'h000000F0, 4'b0000, 32'h000000FF, 4'b0000, 1'b1));
    vecs.push_back(mk(OP_MOV, 32'h12345678, 32'h0,        4'b0110, 32'h00000000, 4'b0011, 1'b1));
    vecs.push_back(mk(OP_BIC, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0000, 32'hFFFF0000, 4'b0100, 1'b1));
    vecs.push_back(mk(OP_MVN, 32'h0,        32'h0,        4'b0000, 32'hFFFFFFFF, 4'b0100, 1'b1));
    vecs.push_back(mk(OP_ADD, 32'h80000000, 32'h80000000, 4'b0000, 32'h00000000, 4'b1011, 1'b1));
    vecs.push_back(mk(OP_SUB, 32'h80000000, 32'd1,        4'b0000, 32'h7FFFFFFF, 4'b1010, 1'b1));
    vecs.push_back(mk(OP_MUL, 32'd6,        32'd7,        4'b0000, 32'd42,       4'b0000, 1'b1));
    vecs.push_back(mk(OP_MUL, 32'h00010000, 32'h00010000, 4'b1010, 32'h00000000, 4'b1011, 1'b1));
    vecs.push_back(mk(5'b10101, 32'hDEADBEEF, 32'h1,      4'b0101, 32'h00000000, 4'b0101, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      e.op = vecs[i].op; e.res = vecs[i].res; e.flg = vecs[i].flg; e.wb = vecs[i].wb;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fin, 1'b1, e);
    end
    drain();

    // Random ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      rop = 5'($urandom_range(0, 17));
      ra  = $urandom();
      rb  = (i % 5 == 0) ? ra : $urandom();
      rf  = 4'($urandom_range(0, 15));
      issue(rop, ra, rb, rf, 1'b1, model(rop, ra, rb, rf));
    end
    drain();

    // Backpressure: result held for 3 cycles, then a same-edge accept.
    out_ready = 1'b0;
    e.op = OP_ADD; e.res = 32'd3; e.flg = 4'b0000; e.wb = 1'b1;
    issue(OP_ADD, 32'd1, 32'd2, 4'b0000, 1'b1, e);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_result", result, W'(3));
      check("hold_in_ready", W'(in_ready), W'(0));
      @(posedge clk); #1;
    end
    e.op = OP_ADD; e.res = 32'd30; e.flg = 4'b0000; e.wb = 1'b1;
    sb_q.push_back(e);
    operation = OP_ADD; data1 = 32'd10; data2 = 32'd20; flags_in = 4'b0000;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("same_edge_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("same_edge_out_valid", W'(out_valid), W'(1));
    check("same_edge_result", result, W'(30));
    for (int i = 1; i <= 4; i++) begin
      e.op = OP_ADD; e.res = W'(i * 4); e.flg = 4'b0000; e.wb = 1'b1;
      issue(OP_ADD, W'(i), W'(i * 3), 4'b0000, 1'b1, e);
      check("b2b_out_valid", W'(out_valid), W'(1));
    end
    drain();

    // MUL latency and in_ready low throughout.
    e.op = OP_MUL; e.res = 32'd42; e.flg = 4'b0000; e.wb = 1'b1;
    issue(OP_MUL, 32'd6, 32'd7, 4'b0000, 1'b1, e);
    k = 0;
    ready_low = 1'b1;
    while (!out_valid && k < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check("mul_latency", W'(k), W'(33));
    check("mul_in_ready_low", W'(ready_low), W'(1));
    drain();

    // Async reset in the middle of a MUL discards it.
    issue(OP_MUL, 32'd123, 32'd456, 4'b0000, 1'b0, e);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_reset_out_valid", W'(out_valid), W'(0));
    check("mid_reset_result", result, W'(0));
    check("mid_reset_flags", W'(flags), W'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("release_in_ready", W'(in_ready), W'(1));
    e.op = 5'b10101; e.res = 32'd0; e.flg = 4'b1010; e.wb = 1'b0;
    issue(5'b10101, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010, 1'b1, e);
    check("undef_out_valid", W'(out_valid), W'(1));
    drain();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
